// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  // Replicated across the quotient width when the divisor is zero.
  localparam logic DBZ_QUOTIENT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/cla_subtractor.sv
// Carry-lookahead subtractor: diff = a - b computed as a + ~b + 1.
module cla_subtractor #(
  parameter int unsigned WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH-1:0] w_bn;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_prod;

  assign w_bn = ~b;
  assign w_g  = a & w_bn;
  assign w_p  = a ^ w_bn;

  // Each carry is a flat sum-of-products of generates/propagates; carry-in is 1.
  always_comb begin
    w_c    = '0;
    w_c[0] = 1'b1;
    w_prod = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_prod   = w_p[i];
      w_c[i+1] = w_g[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_prod & w_g[j]);
        w_prod   = w_prod & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | w_prod;
    end
  end

  assign diff   = w_p ^ w_c[WIDTH-1:0];
  assign borrow = ~w_c[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle,
// with valid/ready handshakes on operands and result.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_r, w_r_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dbz, w_dbz_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;

  // Partial remainder keeps the shifted-out MSB so the borrow is unambiguous.
  assign w_rs = {r_r, r_q[WIDTH-1]};

  cla_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a      (w_rs),
    .b      ({1'b0, r_d}),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_dbz_nxt   = r_dbz;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_d_nxt   = divisor;
          w_cnt_nxt = CNT_W'(WIDTH);
          if (divisor == '0) begin
            w_q_nxt     = {WIDTH{DBZ_QUOTIENT}};
            w_r_nxt     = dividend;
            w_dbz_nxt   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_q_nxt     = dividend;
            w_r_nxt     = '0;
            w_dbz_nxt   = 1'b0;
            w_state_nxt = CALC;
          end
        end
      end
      CALC: begin
        w_q_nxt   = {r_q[WIDTH-2:0], ~w_borrow};
        w_r_nxt   = WIDTH'(w_borrow ? w_rs : w_diff);
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_q         <= '0;
      r_r         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_q         <= w_q_nxt;
      r_r         <= w_r_nxt;
      r_d         <= w_d_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dbz       <= w_dbz_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, multi-cycle
// corner sequences and a randomized stream against a reference model.
module tb_seq_divider;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errs   = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then wait (bounded) for out_valid.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input bit junk, output int lat);
    chk("in_ready_at_launch", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_result(input vec_t v, input int lat);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("quotient", 32'(quotient), 32'(v.q));
    chk("remainder", 32'(remainder), 32'(v.r));
    chk("div_by_zero", 32'(div_by_zero), 32'(v.dbz));
    chk("latency", 32'(lat), 32'(v.lat));
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    if (v.dvs != 8'd0) begin
      chk("invariant_sum", 32'(quotient) * 32'(v.dvs) + 32'(remainder), 32'(v.dvd));
      chk("invariant_rem_lt_div", 32'(remainder < v.dvs), 32'd1);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_cleared", 32'(out_valid), 32'd0);
    chk("in_ready_returns", 32'(in_ready), 32'd1);
  endtask

  function automatic vec_t model(input logic [7:0] a, input logic [7:0] b);
    vec_t v;
    v.dvd = a;
    v.dvs = b;
    if (b == 8'd0) begin
      v.q = 8'hFF; v.r = a; v.dbz = 1'b1; v.lat = 1;
    end else begin
      v.q = a / b; v.r = a % b; v.dbz = 1'b0; v.lat = 9;
    end
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    vec_t v;
    logic [7:0] a;
    logic [7:0] b;

    vecs[0] = '{dvd: 8'd100, dvs: 8'd7,   q: 8'd14,  r: 8'd2,  dbz: 1'b0, lat: 9};
    vecs[1] = '{dvd: 8'd5,   dvs: 8'd0,   q: 8'hFF,  r: 8'd5,  dbz: 1'b1, lat: 1};
    vecs[2] = '{dvd: 8'd255, dvs: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0, lat: 9};
    vecs[3] = '{dvd: 8'd3,   dvs: 8'd200, q: 8'd0,   r: 8'd3,  dbz: 1'b0, lat: 9};
    vecs[4] = '{dvd: 8'd255, dvs: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0, lat: 9};
    vecs[5] = '{dvd: 8'd0,   dvs: 8'd9,   q: 8'd0,   r: 8'd0,  dbz: 1'b0, lat: 9};
    vecs[6] = '{dvd: 8'd77,  dvs: 8'd3,   q: 8'd25,  r: 8'd2,  dbz: 1'b0, lat: 9};
    vecs[7] = '{dvd: 8'd0,   dvs: 8'd0,   q: 8'hFF,  r: 8'd0,  dbz: 1'b1, lat: 1};
    vecs[8] = '{dvd: 8'd1,   dvs: 8'd255, q: 8'd0,   r: 8'd1,  dbz: 1'b0, lat: 9};
    vecs[9] = '{dvd: 8'd254, dvs: 8'd16,  q: 8'd15,  r: 8'd14, dbz: 1'b0, lat: 9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Directed vector table; the first entry runs with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      out_ready = (i == 0);
      launch(vecs[i].dvd, vecs[i].dvs, 1'b0, lat);
      check_result(vecs[i], lat);
      release_out();
      step();
    end

    // Long backpressure with ignored in_valid traffic during the stall.
    v = model(8'd200, 8'd13);
    launch(v.dvd, v.dvs, 1'b1, lat);
    check_result(v, lat);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd3;
      step();
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_quotient", 32'(quotient), 32'd15);
      chk("stall_remainder", 32'(remainder), 32'd5);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out();

    // Reset asserted in the 4th CALC cycle abandons the operation.
    dividend = 8'd77; divisor = 8'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_quotient", 32'(quotient), 32'd0);
    chk("midreset_remainder", 32'(remainder), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("postreset_no_result", 32'(out_valid), 32'd0);
    v = model(8'd77, 8'd3);
    launch(v.dvd, v.dvs, 1'b0, lat);
    check_result(v, lat);
    release_out();

    // Randomized stream with junk in_valid and random backpressure.
    for (int n = 0; n < 1500; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom);
      v = model(a, b);
      repeat ($urandom_range(0, 2)) step();
      launch(a, b, 1'b1, lat);
      chk("rand_quotient", 32'(quotient), 32'(v.q));
      chk("rand_remainder", 32'(remainder), 32'(v.r));
      chk("rand_dbz", 32'(div_by_zero), 32'(v.dbz));
      chk("rand_latency", 32'(lat), 32'(v.lat));
      for (int k = 0; k < 6 && $urandom_range(0, 2) == 0; k++) begin
        step();
        chk("rand_hold", 32'({out_valid, quotient, remainder}), 32'({1'b1, v.q, v.r}));
      end
      release_out();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
